// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer. Fetch lookup is combinational. Execute-stage
// updates train 2-bit saturating counters and register a one-cycle mispredict flag.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_f,
  output logic            hit_f,
  output logic            pred_taken_f,
  output logic [PC_W-1:0] target_f,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  input  logic            flush,
  output logic            mispred
);

  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit, u_pred, u_mis;
  logic             unused_low_bits;

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[PC_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[PC_W-1:IDX_W+2];

  // Instructions are word-aligned, so the low two PC bits never select anything.
  assign unused_low_bits = ^{pc_f[1:0], upd_pc[1:0]};

  // The rst term forces the outputs low as soon as reset asserts.
  assign hit_f        = rst & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
  assign pred_taken_f = hit_f & ctr_q[f_idx][1];
  assign target_f     = hit_f ? target_q[f_idx] : '0;

  // Prediction that fetch would have made for the branch being resolved.
  assign u_hit  = valid_q[u_idx] & (tag_q[u_idx] == u_tag);
  assign u_pred = u_hit & ctr_q[u_idx][1];
  assign u_mis  = (u_pred != upd_taken) ||
                  (u_pred && upd_taken && (target_q[u_idx] != upd_target));

  // NOTE: the table is small enough to reset in full, which guarantees a defined
  // counter and target for every entry after reset. All state uses non-blocking
  // assignments, so a lookup always sees the contents from before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= SNT;
      end
      mispred <= 1'b0;
    end else begin
      mispred <= upd_en & u_mis;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (upd_en) begin
        if (u_hit) begin
          if (upd_taken) begin
            ctr_q[u_idx]    <= (ctr_q[u_idx] == ST) ? ST : ctr_q[u_idx] + 2'd1;
            target_q[u_idx] <= upd_target;
          end else begin
            ctr_q[u_idx]    <= (ctr_q[u_idx] == SNT) ? SNT : ctr_q[u_idx] - 2'd1;
          end
        end else if (upd_taken) begin
          valid_q[u_idx]  <= 1'b1;
          tag_q[u_idx]    <= u_tag;
          target_q[u_idx] <= upd_target;
          ctr_q[u_idx]    <= WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios with fixed
// expectations, then random traffic compared against a table model.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f, upd_pc, upd_target;
  logic        upd_en, upd_taken, flush;
  logic        hit_f, pred_taken_f, mispred;
  logic [31:0] target_f;

  int checks = 0;
  int errors = 0;

  branch_target_buffer #(.ENTRIES(16), .IDX_W(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .hit_f(hit_f), .pred_taken_f(pred_taken_f),
    .target_f(target_f), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush(flush), .mispred(mispred)
  );

  always #5 clk = ~clk;

  // Reference model: one record per index, with counter values 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
  endfunction

  function automatic void model_lookup(input int unsigned pc, output bit h,
                                       output bit p, output int unsigned t);
    int idx;
    idx = (pc / 4) % 16;
    h = m_valid[idx] && (m_tag[idx] == pc / 64);
    p = h && (m_ctr[idx] >= 2);
    t = h ? m_tgt[idx] : 0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    upd_en = 0; upd_taken = 0; flush = 0; upd_pc = '0; upd_target = '0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); pc_f = 32'h100;
    tick(); tick();
    checks++;
    if ({hit_f, pred_taken_f, target_f, mispred} !== 35'd0) begin
      errors++;
      $display("FAIL reset_hold: hit=%0b pred=%0b tgt=%h mis=%0b, expected all 0",
               hit_f, pred_taken_f, target_f, mispred);
    end
    rst = 1; tick();
    checks++;
    if ({hit_f, pred_taken_f, target_f, mispred} !== 35'd0) begin
      errors++;
      $display("FAIL reset_lookup_0x100: hit=%0b pred=%0b tgt=%h mis=%0b, expected all 0",
               hit_f, pred_taken_f, target_f, mispred);
    end
  endtask

  task automatic test_alloc();
    upd_en = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h240; pc_f = 32'h100;
    @(negedge clk);
    checks++;
    if (hit_f !== 1'b0) begin
      errors++; $display("FAIL alloc_same_cycle: hit=%0b, expected 0", hit_f);
    end
    tick(); idle();
    checks++;
    if ({hit_f, pred_taken_f, target_f, mispred} !== {1'b1, 1'b1, 32'h240, 1'b1}) begin
      errors++;
      $display("FAIL alloc_next: hit=%0b pred=%0b tgt=%h mis=%0b, expected 1 1 00000240 1",
               hit_f, pred_taken_f, target_f, mispred);
    end
    tick();
    checks++;
    if (mispred !== 1'b0) begin
      errors++; $display("FAIL mispred_clear: mis=%0b, expected 0", mispred);
    end
  endtask

  // Entry 0x100 starts at WT with target 0x240.
  task automatic test_counter();
    bit          taken [11] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    int unsigned tgt   [11] = '{'h240, 'h240, 'h240, 'h240, 'h240, 'h240, 'h240,
                                'h240, 'h240, 'h380, 'h380};
    bit          e_pred[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    bit          e_mis [11] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 0};
    int unsigned e_tgt [11] = '{'h240, 'h240, 'h240, 'h240, 'h240, 'h240, 'h240,
                                'h240, 'h240, 'h380, 'h380};
    pc_f = 32'h100;
    for (int i = 0; i < 11; i++) begin
      upd_en = 1; upd_pc = 32'h100; upd_taken = taken[i]; upd_target = tgt[i];
      tick();
      checks++;
      if ({hit_f, pred_taken_f, target_f, mispred} !== {1'b1, e_pred[i], e_tgt[i], e_mis[i]}) begin
        errors++;
        $display("FAIL counter_step%0d: hit=%0b pred=%0b tgt=%h mis=%0b, expected 1 %0b %h %0b",
                 i, hit_f, pred_taken_f, target_f, mispred, e_pred[i], e_tgt[i], e_mis[i]);
      end
    end
    idle();
  endtask

  task automatic test_alias();
    upd_en = 1; upd_pc = 32'h140; upd_taken = 1; upd_target = 32'h500;
    tick(); idle();
    checks++;
    if (mispred !== 1'b1) begin
      errors++; $display("FAIL alias_mispred: mis=%0b, expected 1", mispred);
    end
    pc_f = 32'h100; #1;
    checks++;
    if (hit_f !== 1'b0) begin
      errors++; $display("FAIL alias_old_tag: hit=%0b, expected 0", hit_f);
    end
    pc_f = 32'h140; #1;
    checks++;
    if ({hit_f, pred_taken_f, target_f} !== {1'b1, 1'b1, 32'h500}) begin
      errors++;
      $display("FAIL alias_new_tag: hit=%0b pred=%0b tgt=%h, expected 1 1 00000500",
               hit_f, pred_taken_f, target_f);
    end
    // A single not-taken step must drop the new entry to weakly-not-taken.
    upd_en = 1; upd_pc = 32'h140; upd_taken = 0;
    tick(); idle();
    checks++;
    if ({hit_f, pred_taken_f} !== 2'b10) begin
      errors++;
      $display("FAIL alias_alloc_wt: hit=%0b pred=%0b, expected 1 0", hit_f, pred_taken_f);
    end
  endtask

  task automatic test_same_cycle();
    pc_f = 32'h104; upd_en = 1; upd_pc = 32'h104; upd_taken = 1; upd_target = 32'h600;
    @(negedge clk);
    checks++;
    if (hit_f !== 1'b0) begin
      errors++; $display("FAIL same_cycle_no_bypass: hit=%0b, expected 0", hit_f);
    end
    tick(); idle();
    checks++;
    if ({hit_f, target_f} !== {1'b1, 32'h600}) begin
      errors++;
      $display("FAIL same_cycle_next: hit=%0b tgt=%h, expected 1 00000600", hit_f, target_f);
    end
    pc_f = 32'h10C; upd_en = 1; upd_pc = 32'h10C; upd_taken = 0; upd_target = 32'h700;
    tick(); idle();
    checks++;
    if ({hit_f, mispred} !== 2'b00) begin
      errors++;
      $display("FAIL miss_not_taken: hit=%0b mis=%0b, expected 0 0", hit_f, mispred);
    end
  endtask

  task automatic test_flush();
    int unsigned pcs [5] = '{'h100, 'h104, 'h108, 'h140, 'h10C};
    flush = 1; upd_en = 1; upd_pc = 32'h108; upd_taken = 1; upd_target = 32'h700;
    tick(); idle();
    checks++;
    if (mispred !== 1'b1) begin
      errors++; $display("FAIL flush_mispred: mis=%0b, expected 1", mispred);
    end
    for (int i = 0; i < 5; i++) begin
      pc_f = pcs[i]; #1;
      checks++;
      if (hit_f !== 1'b0) begin
        errors++; $display("FAIL flush_miss_%h: hit=%0b, expected 0", pcs[i], hit_f);
      end
    end
  endtask

  task automatic test_async_reset();
    upd_en = 1; upd_pc = 32'h100; upd_taken = 1; upd_target = 32'h240; pc_f = 32'h100;
    tick();
    upd_pc = 32'h104; upd_target = 32'h900;
    #1;
    checks++;
    if ({hit_f, mispred} !== 2'b11) begin
      errors++; $display("FAIL pre_reset: hit=%0b mis=%0b, expected 1 1", hit_f, mispred);
    end
    #1 rst = 0; #1;
    checks++;
    if ({hit_f, pred_taken_f, target_f, mispred} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: hit=%0b pred=%0b tgt=%h mis=%0b, expected all 0",
               hit_f, pred_taken_f, target_f, mispred);
    end
    #2 rst = 1;
    tick(); idle();
    pc_f = 32'h104; #1;
    checks++;
    if ({hit_f, target_f, mispred} !== {1'b1, 32'h900, 1'b1}) begin
      errors++;
      $display("FAIL post_release_update: hit=%0b tgt=%h mis=%0b, expected 1 00000900 1",
               hit_f, target_f, mispred);
    end
    pc_f = 32'h100; #1;
    checks++;
    if (hit_f !== 1'b0) begin
      errors++; $display("FAIL reset_wiped: hit=%0b, expected 0", hit_f);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned tag;
    tag = $urandom_range(0, 2);
    if ($urandom_range(0, 7) == 0) tag = tag | 32'h0200_0000;
    return (tag << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
  endfunction

  task automatic test_random();
    int unsigned tgts [3] = '{'h200, 'h400, 'h800};
    bit          eh, ep, uh, up, em;
    int unsigned et, ut;
    int          idx;
    rst = 0; idle(); model_reset(); tick(); rst = 1;
    for (int n = 0; n < 400; n++) begin
      pc_f       = ($urandom_range(0, 2) == 0) ? upd_pc : rand_pc();
      upd_en     = $urandom_range(0, 3) != 0;
      upd_pc     = rand_pc();
      upd_taken  = $urandom_range(0, 2) != 0;
      upd_target = tgts[$urandom_range(0, 2)];
      flush      = $urandom_range(0, 24) == 0;
      @(negedge clk);
      model_lookup(pc_f, eh, ep, et);
      checks++;
      if ({hit_f, pred_taken_f, target_f} !== {eh, ep, et}) begin
        errors++;
        $display("FAIL rand_lookup n=%0d pc=%h: hit=%0b pred=%0b tgt=%h, expected %0b %0b %h",
                 n, pc_f, hit_f, pred_taken_f, target_f, eh, ep, et);
      end
      model_lookup(upd_pc, uh, up, ut);
      em = upd_en && ((up != upd_taken) || (up && upd_taken && ut != upd_target));
      idx = (upd_pc / 4) % 16;
      tick();
      if (flush) begin
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
      end else if (upd_en) begin
        if (uh) begin
          m_ctr[idx] = upd_taken ? ((m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1)
                                 : ((m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1);
          if (upd_taken) m_tgt[idx] = upd_target;
        end else if (upd_taken) begin
          m_valid[idx] = 1; m_tag[idx] = upd_pc / 64; m_tgt[idx] = upd_target; m_ctr[idx] = 2;
        end
      end
      checks++;
      if (mispred !== em) begin
        errors++;
        $display("FAIL rand_mispred n=%0d: mis=%0b, expected %0b", n, mispred, em);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_same_cycle();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
